// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the multi-cycle RV32M execute unit.
// Op codes follow funct3 so the decoder can pass the field straight through.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic op_signed_a(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the EX stage and the mul/div unit.
// The pipeline side is the master; the unit is the slave.
interface ex_muldiv_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start_i;
    logic [2:0]            op_i;
    logic [XLEN-1:0]       reg1_i;
    logic [XLEN-1:0]       reg2_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic                  rd_e_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  busy_o;
    logic                  valid_o;
    logic [XLEN-1:0]       rd_data_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic                  rd_e_o;

    modport master (
        output start_i, op_i, reg1_i, reg2_i, rd_i, rd_e_i, flush_i,
        input  stall_o, busy_o, valid_o, rd_data_o, rd_addr_o, rd_e_o
    );

    modport slave (
        input  start_i, op_i, reg1_i, reg2_i, rd_i, rd_e_i, flush_i,
        output stall_o, busy_o, valid_o, rd_data_o, rd_addr_o, rd_e_o
    );
endinterface

// File: rtl/ex_muldiv_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    assign result = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M unit: one bit per cycle shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied in DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    md_state_e             state;
    md_state_e             state_next;
    md_op_e                op;
    md_op_e                op_in;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_e;
    logic                  neg_res;
    logic [CNT_W-1:0]      count;
    logic [XLEN-1:0]       a_mag;
    logic [XLEN-1:0]       b_mag;
    logic [2*XLEN-1:0]     acc;

    logic                  start_ok;
    logic                  a_neg;
    logic                  b_neg;
    logic [XLEN-1:0]       a_abs;
    logic [XLEN-1:0]       b_abs;
    logic                  div_zero;
    logic                  div_ovf;

    logic [XLEN-1:0]       addend;
    logic [XLEN:0]         mul_sum;
    logic [2*XLEN-1:0]     mul_next;
    logic [XLEN:0]         rem_shift;
    logic [XLEN:0]         div_diff;
    logic [2*XLEN-1:0]     div_next;

    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       quot_fix;
    logic [XLEN-1:0]       rem_fix;
    logic [XLEN-1:0]       result;

    logic                  valid;
    logic [XLEN-1:0]       rd_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_e_out;

    assign op_in    = md_op_e'(bus.op_i);
    assign start_ok = (state == ST_IDLE) && bus.start_i && !bus.flush_i;
    assign a_neg    = op_signed_a(op_in) && bus.reg1_i[XLEN-1];
    assign b_neg    = op_signed_b(op_in) && bus.reg2_i[XLEN-1];
    assign div_zero = op_in[2] && (bus.reg2_i == '0);
    assign div_ovf  = (op_in == MD_DIV || op_in == MD_REM)
                      && (bus.reg1_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.reg2_i == '1);

    md_sign_fix #(.WIDTH(XLEN)) u_fix_a (
        .value(bus.reg1_i), .negate(a_neg), .result(a_abs)
    );
    md_sign_fix #(.WIDTH(XLEN)) u_fix_b (
        .value(bus.reg2_i), .negate(b_neg), .result(b_abs)
    );
    md_sign_fix #(.WIDTH(2*XLEN)) u_fix_prod (
        .value(acc), .negate(neg_res), .result(prod_fix)
    );
    md_sign_fix #(.WIDTH(XLEN)) u_fix_quot (
        .value(acc[XLEN-1:0]), .negate(neg_res), .result(quot_fix)
    );
    md_sign_fix #(.WIDTH(XLEN)) u_fix_rem (
        .value(acc[2*XLEN-1:XLEN]), .negate(neg_res), .result(rem_fix)
    );

    // Multiply keeps the multiplier in the low half and shifts the partial
    // product in from the top; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        addend    = acc[0] ? a_mag : '0;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = rem_shift - {1'b0, b_mag};
        if (div_diff[XLEN]) begin
            div_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        result = rem_fix;
        unique case (op)
            MD_MUL:                       result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = quot_fix;
            default:                      result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start_ok) state_next = (div_zero || div_ovf) ? ST_DONE : ST_CALC;
            ST_CALC: if (count == CNT_W'(XLEN-1)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (bus.flush_i) state_next = ST_IDLE;
    end

    // Fast-path results are loaded pre-signed so DONE needs no special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op       <= MD_MUL;
            rd       <= '0;
            rd_e     <= 1'b0;
            neg_res  <= 1'b0;
            count    <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            valid    <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            rd_e_out <= 1'b0;
        end else begin
            valid    <= 1'b0;
            rd_e_out <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        op      <= op_in;
                        rd      <= bus.rd_i;
                        rd_e    <= bus.rd_e_i;
                        count   <= '0;
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        neg_res <= op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
                        if (div_zero) begin
                            acc     <= {bus.reg1_i, {XLEN{1'b1}}};
                            neg_res <= 1'b0;
                        end else if (div_ovf) begin
                            acc     <= {{XLEN{1'b0}}, bus.reg1_i};
                            neg_res <= 1'b0;
                        end else if (op_in[2]) begin
                            acc <= {{XLEN{1'b0}}, a_abs};
                        end else begin
                            acc <= {{XLEN{1'b0}}, b_abs};
                        end
                    end
                end
                ST_CALC: begin
                    acc   <= op[2] ? div_next : mul_next;
                    count <= count + CNT_W'(1);
                end
                ST_DONE: begin
                    if (!bus.flush_i) begin
                        valid    <= 1'b1;
                        rd_data  <= result;
                        rd_addr  <= rd;
                        rd_e_out <= rd_e;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_o   = start_ok || (state != ST_IDLE);
    assign bus.busy_o    = (state != ST_IDLE);
    assign bus.valid_o   = valid;
    assign bus.rd_data_o = rd_data;
    assign bus.rd_addr_o = rd_addr;
    assign bus.rd_e_o    = rd_e_out;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table for results and latency, plus
// hand-written flush, busy-start and asynchronous-reset sequences.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RW-1:0]   rd;
        logic            rd_e;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

    ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [RW-1:0] rd, input logic rd_e);
        bus.op_i   = op;
        bus.reg1_i = a;
        bus.reg2_i = b;
        bus.rd_i   = rd;
        bus.rd_e_i = rd_e;
    endtask

    // Called just after a rising edge; that cycle is cycle 0.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [RW-1:0] rd, input logic rd_e,
                          input logic [31:0] exp, input int lat);
        bit seen = 0;
        drive(op, a, b, rd, rd_e);
        bus.start_i = 1'b1;
        sample();
        check({name, " stall0"}, 32'(bus.stall_o), 32'd1);
        next_cycle();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            sample();
            if (bus.valid_o) begin
                seen = 1;
                check({name, " latency"}, 32'(c), 32'(lat));
                check({name, " data"}, bus.rd_data_o, exp);
                check({name, " rd_addr"}, 32'(bus.rd_addr_o), 32'(rd));
                check({name, " rd_e"}, 32'(bus.rd_e_o), 32'(rd_e));
                check({name, " stall_at_valid"}, 32'(bus.stall_o), 32'd0);
            end else begin
                next_cycle();
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no valid_o, expected one by cycle %0d", name, lat);
        end else begin
            next_cycle();
            sample();
            check({name, " pulse"}, 32'(bus.valid_o), 32'd0);
            check({name, " hold"}, bus.rd_data_o, exp);
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFFFFFD, 5'd1,  1'b1, 32'hFFFFFFEB, 34};
        vecs[1]  = '{MD_MULH,   32'h80000000,   32'h80000000, 5'd2,  1'b1, 32'h40000000, 34};
        vecs[2]  = '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  1'b1, 32'hFFFFFFFE, 34};
        vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4,  1'b1, 32'hFFFFFFFF, 34};
        vecs[4]  = '{MD_DIV,    32'hFFFFFFF9,   32'd2,        5'd5,  1'b1, 32'hFFFFFFFD, 34};
        vecs[5]  = '{MD_REM,    32'hFFFFFFF9,   32'd2,        5'd6,  1'b1, 32'hFFFFFFFF, 34};
        vecs[6]  = '{MD_DIVU,   32'd100,        32'd7,        5'd7,  1'b1, 32'd14,       34};
        vecs[7]  = '{MD_REMU,   32'd100,        32'd7,        5'd8,  1'b1, 32'd2,        34};
        vecs[8]  = '{MD_DIV,    32'd5,          32'd0,        5'd9,  1'b1, 32'hFFFFFFFF, 2};
        vecs[9]  = '{MD_REM,    32'd5,          32'd0,        5'd10, 1'b1, 32'd5,        2};
        vecs[10] = '{MD_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd11, 1'b1, 32'h80000000, 2};
        vecs[11] = '{MD_REM,    32'h80000000,   32'hFFFFFFFF, 5'd12, 1'b1, 32'd0,        2};
        vecs[12] = '{MD_DIV,    32'd7,          32'hFFFFFFFE, 5'd13, 1'b1, 32'hFFFFFFFD, 34};
        vecs[13] = '{MD_REM,    32'd7,          32'hFFFFFFFE, 5'd14, 1'b1, 32'd1,        34};
        vecs[14] = '{MD_MUL,    32'h12345678,   32'h10,       5'd15, 1'b1, 32'h23456780, 34};
        vecs[15] = '{MD_REMU,   32'hFFFFFFFF,   32'h10,       5'd16, 1'b0, 32'h0000000F, 34};

        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(3'b000, '0, '0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 32'(bus.valid_o), 32'd0);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset stall", 32'(bus.stall_o), 32'd0);
        check("reset data", bus.rd_data_o, 32'd0);
        check("reset rd_e", 32'(bus.rd_e_o), 32'd0);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].rd, vecs[i].rd_e, vecs[i].exp, vecs[i].lat);
        end

        // Flush mid-divide: no result, unit idle the next cycle.
        drive(MD_DIVU, 32'd100, 32'd7, 5'd20, 1'b1);
        bus.start_i = 1'b1;
        next_cycle();
        bus.start_i = 1'b0;
        saw_valid = 0;
        for (int c = 1; c < 10; c++) begin
            sample();
            saw_valid |= bus.valid_o;
            next_cycle();
        end
        sample();
        check("flush busy before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        next_cycle();
        bus.flush_i = 1'b0;
        sample();
        saw_valid |= bus.valid_o;
        check("flush busy", 32'(bus.busy_o), 32'd0);
        check("flush stall", 32'(bus.stall_o), 32'd0);
        check("flush no valid", 32'(saw_valid), 32'd0);
        next_cycle();
        run_op("after_flush", MD_DIVU, 32'd100, 32'd7, 5'd21, 1'b1, 32'd14, 34);

        // start held high with changing operands while busy.
        drive(MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b1);
        bus.start_i = 1'b1;
        next_cycle();
        drive(MD_DIVU, 32'd100, 32'd7, 5'd3, 1'b0);
        saw_valid = 0;
        for (int c = 1; c <= 40 && !saw_valid; c++) begin
            sample();
            if (bus.valid_o) begin
                saw_valid = 1;
                check("busy_start latency", 32'(c), 32'd34);
                check("busy_start data", bus.rd_data_o, 32'hFFFFFFEB);
                check("busy_start rd_addr", 32'(bus.rd_addr_o), 32'd9);
                check("busy_start rd_e", 32'(bus.rd_e_o), 32'd1);
            end else begin
                next_cycle();
            end
        end
        if (!saw_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_start timeout: got no valid_o, expected one by cycle 34");
        end
        next_cycle();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        next_cycle();
        bus.flush_i = 1'b0;
        sample();
        check("busy_start cleanup", 32'(bus.busy_o), 32'd0);
        next_cycle();

        // Asynchronous reset between edges while in CALC.
        drive(MD_DIVU, 32'd100, 32'd7, 5'd22, 1'b1);
        bus.start_i = 1'b1;
        next_cycle();
        bus.start_i = 1'b0;
        repeat (4) next_cycle();
        #3;
        rst = 1'b1;
        #1;
        check("arst busy", 32'(bus.busy_o), 32'd0);
        check("arst stall", 32'(bus.stall_o), 32'd0);
        check("arst data", bus.rd_data_o, 32'd0);
        check("arst valid", 32'(bus.valid_o), 32'd0);
        #1;
        rst = 1'b0;
        next_cycle();
        run_op("after_reset", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 1'b1, 32'hFFFFFFFE, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle RV32M execute unit. Sits beside the single-cycle ALU in the EX stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op at a time.
- Iterates one bit per cycle and holds the pipeline with a stall signal until the result is ready.
- Result, rd address and write enable are presented to EX/MEM for one cycle.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
REG_ADDR_W, 5, destination register address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  issue request; sampled only in IDLE
op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
reg1_i  in  XLEN  rs1 operand (multiplicand/dividend)
reg2_i  in  XLEN  rs2 operand (multiplier/divisor)
rd_i  in  REG_ADDR_W  destination register
rd_e_i  in  1  destination write enable
flush_i  in  1  branch-mispredict flush; aborts in-flight op
stall_o  out  1  hold IF/ID/EX while op pending
busy_o  out  1  state != IDLE
valid_o  out  1  one-cycle result strobe
rd_data_o  out  XLEN  result
rd_addr_o  out  REG_ADDR_W  latched rd
rd_e_o  out  1  valid_o & latched rd_e

Behaviour:
- Reset: clk and rst as named; rst asynchronous, active-high. All outputs 0; state IDLE; counter 0; internal regs 0.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch op, rd, rd_e.
  - Form operand magnitudes: signed ops negate negative operands. MULHSU treats rs2 unsigned.
  - Record result sign. Products: sign(a)^sign(b). Quotient: sign(a)^sign(b). Remainder: sign(a).
- Fast path, decided in the start cycle:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - DIV/REM with rs1=0x80000000, rs2=-1: quotient = 0x80000000; remainder = 0.
  - Either case: go directly to DONE.
- Otherwise go to CALC with counter=0.
- CALC, one step per cycle, exactly XLEN cycles:
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring step (shift remainder left, conditional subtract, quotient bit).
  - Counter == XLEN-1 -> DONE.
- DONE (one cycle):
  - Apply sign correction: negate the 2*XLEN product, or the quotient/remainder, as recorded.
  - Select the result: MUL low XLEN; MULH/MULHSU/MULHU high XLEN; DIV/DIVU quotient; REM/REMU remainder.
  - Register the result; valid_o=1 in the following cycle.
  - Return to IDLE.
- Latency (start cycle = cycle 0):
  - Normal: valid_o in cycle XLEN+2.
  - Fast path: valid_o in cycle 2.
- rd_data_o and rd_addr_o hold their value until the next valid_o. valid_o and rd_e_o are single-cycle pulses.
- stall_o is combinational:
  - (IDLE & start_i & !flush_i) | CALC | DONE.
  - Deasserts in the cycle valid_o is high so the pipeline advances with the result.
- busy_o = state != IDLE.
- start_i while busy: ignored, with no effect on the in-flight op.
- flush_i in any state:
  - Next state IDLE; no valid_o is produced.
  - Flush in the same cycle as start_i: start is not accepted.
  - Flush in the cycle valid_o is high: that pulse stands, because the op already completed.
- Reset mid-operation: immediate return to IDLE; outputs 0.
- Arithmetic is all unsigned on magnitudes. Sign negation is two's complement at full width. No X propagation from unused accumulator bits.

Decomposition:
- Op encodings (MD_MUL..MD_REMU) and state encodings go into config.v as shared defines next to the existing AluOp codes.
- One sub-module is natural: md_sign_fix (combinational conditional two's-complement negate, parametrised width). It is instantiated for operand magnitude, product, quotient and remainder.

Test Plan:
- MUL 7 x -3 -> valid_o in cycle 34, rd_data_o=0xFFFFFFEB. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> valid_o in cycle 2, 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000 in cycle 2. REM of the same operands -> 0.
- Start DIVU, flush_i in cycle 10 -> busy_o=0 in cycle 11, no valid_o, stall_o=0. A new start in cycle 12 completes normally.
- Start asserted continuously with differing operands during CALC -> only the first op's result appears. rd_addr_o/rd_e_o match the first op. rd_e_i=0 gives valid_o=1 with rd_e_o=0.
- rst pulsed asynchronously mid-CALC (between edges) -> all outputs 0 immediately, state IDLE. The next op after release completes with correct latency.
